wq_pool_param: RTL
==================

// Module: wq_pool_param
// PURPOSE
//  Parametrised pool of NUM_WF per-wavefront instruction-PC FIFOs in the wavepool.
//  Fetch reserves a slot (virtual tail), returning fetch data fills it (tail), and issue drains it (head).
//  A single read port muxes out the head PC of one selected wavefront.
//  Adds configurable depth and width, a stop-fetch margin and per-queue occupancy over the fixed 40x64b pool.
// PARAMETERS
//  NUM_WF       40  number of wavefront queues
//  DEPTH        4   entries per queue; power of two, >=2
//  PC_WIDTH     64  bits per entry
//  STOP_MARGIN  0   stop_fetch asserts when reserved >= DEPTH-STOP_MARGIN; must be < DEPTH
// PORTS
//  clk           in   1               clock
//  rst           in   1               synchronous active-high reset
//  q_vtail_incr  in   NUM_WF          reserve one slot in queue w
//  q_wr          in   NUM_WF          write wr_pc into queue w at tail (one-hot or zero)
//  q_rd          in   NUM_WF          pop head of queue w
//  q_reset       in   NUM_WF          flush queue w
//  wr_pc         in   PC_WIDTH        shared write data
//  rd_select     in   $clog2(NUM_WF)  read-port queue index
//  rd_pc         out  PC_WIDTH        head entry of selected queue (combinational)
//  q_empty       out  NUM_WF          head==tail
//  stop_fetch    out  NUM_WF          reservation threshold reached
//  q_count       out  NUM_WF*CNT_W    valid entries per queue, queue w at [w*CNT_W +: CNT_W]
// BEHAVIOUR
//  - One clock (clk); rst is synchronous, active-high. CNT_W = $clog2(DEPTH)+1.
//  - Per queue: head, tail and vtail pointers, CNT_W bits each (MSB = wrap bit).
//    valid = tail-head; reserved = vtail-head (mod 2^CNT_W).
//  - Reset: all pointers 0; q_empty all 1; stop_fetch all 0; q_count all 0; err all 0.
//    Storage not reset.
//  - q_vtail_incr[w]: vtail+1 if pre-cycle reserved < DEPTH, else ignored.
//  - q_wr[w]: mem[tail]<=wr_pc, tail+1, only if pre-cycle tail != vtail; else ignored.
//  - q_rd[w]: head+1 if pre-cycle valid > 0; else ignored. Read-on-empty does not see a same-cycle write.
//  - q_reset[w]: head=tail=vtail=0 next cycle. Dominates rd/wr/vtail_incr on w in the same cycle.
//  - Simultaneous rd+wr+incr on one queue: all legal ops apply together, evaluated on pre-cycle pointers.
//  - Wrap: pointers increment modulo 2^CNT_W; index = ptr[CNT_W-2:0].
//  - Write latency 1: data visible on rd_pc / q_empty the cycle after q_wr.
//  - rd_pc = mem[rd_select][head]; value is don't-care when the queue is empty.
//    rd_pc = 0 when rd_select >= NUM_WF.
//  - q_empty, stop_fetch and q_count are decoded from registered pointers (no input paths).
//  - Multi-hot q_wr: every selected queue captures the same wr_pc. Multi-hot is legal but unused by fetch.
// CONFIGURATION
//  WQ_POOL_ERR_EN defined: adds output err [NUM_WF], sticky per queue, cleared by rst or q_reset[w].
//    Sets the cycle after an ignored op on w: incr when full, write without reservation, or read when empty.
//  Not defined: port absent; ignored ops are silently dropped. Functional behaviour is otherwise identical.
// STRUCTURE
//  - wq_pool_pkg: CNT_W function/localparam, pointer typedef, valid/reserved helper functions.
//  - Sub-module wq_pool_queue: one queue holding pointers, storage, flags and count.
//    The top generates NUM_WF instances plus the read mux and the optional err wiring.
// TESTING
//  1 rst, then DEPTH=4: incr w3 x4, wr 0xA0..0xA3 -> stop_fetch[3]=1 after 4th incr; q_count[3]=4;
//    rd_select=3 gives rd_pc=0xA0.
//  2 5th incr on full w3 -> vtail unchanged; with ERR_EN err[3]=1 next cycle, stays 1 until q_reset[3].
//  3 Queue with 2 valid, rd+wr+incr same cycle -> q_count unchanged (2), reserved unchanged, head advances.
//  4 Fill/drain w0 10 entries cyclically -> pointers wrap; rd_pc order 0..9 exact; q_empty=1 at end.
//  5 q_reset[5] with q_wr[5], q_rd[5] active -> next cycle q_empty[5]=1, q_count[5]=0, stop_fetch[5]=0.
//  6 STOP_MARGIN=1, DEPTH=4: 3rd incr -> stop_fetch=1; rd_select=NUM_WF -> rd_pc=0.

Source files
------------

// File: rtl/wq_pool_pkg.sv
// Shared pointer type, counter-width function and pointer-distance helpers for the wavefront PC pool.
// The optional error outputs are controlled by the macro WQ_POOL_ERR_EN.
package wq_pool_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Distance between two wrap-bit pointers of width cw, masked to cw bits.
  function automatic ptr_t ptr_dist(input ptr_t lead, input ptr_t lag, input int cw);
    ptr_t mask;
    mask = ptr_t'((1 << cw) - 1);
    return (lead - lag) & mask;
  endfunction

  function automatic ptr_t valid_cnt(input ptr_t tail, input ptr_t head, input int cw);
    return ptr_dist(tail, head, cw);
  endfunction

  function automatic ptr_t reserved_cnt(input ptr_t vtail, input ptr_t head, input int cw);
    return ptr_dist(vtail, head, cw);
  endfunction

endpackage

// File: rtl/wq_pool_queue.sv
// One wavefront PC FIFO: head/tail/vtail pointers with wrap bit, storage, flags and occupancy.
// With WQ_POOL_ERR_EN defined, a sticky err_o flags ignored operations.
module wq_pool_queue
  import wq_pool_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 64,
  parameter int STOP_MARGIN = 0,
  localparam int CNT_W      = cnt_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vtail_incr_i,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] wr_pc_i,
  output logic [PC_WIDTH-1:0] head_pc_o,
  output logic                empty_o,
  output logic                stop_fetch_o,
  output logic [CNT_W-1:0]    count_o
`ifdef WQ_POOL_ERR_EN
  , output logic              err_o
`endif
);

  localparam int IDX_W = CNT_W - 1;

  logic [CNT_W-1:0]    head_q, head_d, tail_q, tail_d, vtail_q, vtail_d;
  logic [CNT_W-1:0]    valid, reserved;
  logic                incr_ok, wr_ok, rd_ok;
  logic [PC_WIDTH-1:0] mem_q [DEPTH];

  assign valid    = CNT_W'(valid_cnt(ptr_t'(tail_q), ptr_t'(head_q), CNT_W));
  assign reserved = CNT_W'(reserved_cnt(ptr_t'(vtail_q), ptr_t'(head_q), CNT_W));

  // Legality is judged on pre-cycle pointers so concurrent ops never see each other.
  assign incr_ok = vtail_incr_i && (reserved < CNT_W'(DEPTH));
  assign wr_ok   = wr_i && (tail_q != vtail_q);
  assign rd_ok   = rd_i && (valid != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vtail_d = vtail_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      vtail_d = '0;
    end else begin
      if (rd_ok)   head_d  = head_q + 1'b1;
      if (wr_ok)   tail_d  = tail_q + 1'b1;
      if (incr_ok) vtail_d = vtail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      vtail_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vtail_q <= vtail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush_i) mem_q[tail_q[IDX_W-1:0]] <= wr_pc_i;
  end

  assign head_pc_o    = mem_q[head_q[IDX_W-1:0]];
  assign empty_o      = (head_q == tail_q);
  assign stop_fetch_o = (reserved >= CNT_W'(DEPTH - STOP_MARGIN));
  assign count_o      = valid;

`ifdef WQ_POOL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (vtail_incr_i & ~incr_ok) | (wr_i & ~wr_ok) | (rd_i & ~rd_ok);
    if (flush_i) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: rtl/wq_pool_param.sv
// Parametrised pool of NUM_WF wavefront PC queues with a shared write bus and one head read port.
// Defining WQ_POOL_ERR_EN adds the per-queue sticky err output.
module wq_pool_param
  import wq_pool_pkg::*;
#(
  parameter int NUM_WF      = 40,
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 64,
  parameter int STOP_MARGIN = 0,
  localparam int CNT_W      = cnt_w(DEPTH),
  localparam int SEL_W      = (NUM_WF > 1) ? $clog2(NUM_WF) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WF-1:0]         q_vtail_incr,
  input  logic [NUM_WF-1:0]         q_wr,
  input  logic [NUM_WF-1:0]         q_rd,
  input  logic [NUM_WF-1:0]         q_reset,
  input  logic [PC_WIDTH-1:0]       wr_pc,
  input  logic [SEL_W-1:0]          rd_select,
  output logic [PC_WIDTH-1:0]       rd_pc,
  output logic [NUM_WF-1:0]         q_empty,
  output logic [NUM_WF-1:0]         stop_fetch,
  output logic [NUM_WF*CNT_W-1:0]   q_count
`ifdef WQ_POOL_ERR_EN
  , output logic [NUM_WF-1:0]       err
`endif
);

  logic [PC_WIDTH-1:0] head_pc [NUM_WF];

  for (genvar w = 0; w < NUM_WF; w++) begin : g_q
    wq_pool_queue #(
      .DEPTH       (DEPTH),
      .PC_WIDTH    (PC_WIDTH),
      .STOP_MARGIN (STOP_MARGIN)
    ) u_q (
      .clk          (clk),
      .rst          (rst),
      .vtail_incr_i (q_vtail_incr[w]),
      .wr_i         (q_wr[w]),
      .rd_i         (q_rd[w]),
      .flush_i      (q_reset[w]),
      .wr_pc_i      (wr_pc),
      .head_pc_o    (head_pc[w]),
      .empty_o      (q_empty[w]),
      .stop_fetch_o (stop_fetch[w]),
      .count_o      (q_count[w*CNT_W +: CNT_W])
`ifdef WQ_POOL_ERR_EN
      , .err_o      (err[w])
`endif
    );
  end

  // Out-of-range selects read as zero rather than aliasing onto a real queue.
  always_comb begin
    rd_pc = '0;
    if (32'(rd_select) < NUM_WF) rd_pc = head_pc[rd_select];
  end

endmodule
